// File: rtl/br_lite_ni.sv
// BrLite local network interface: PE-side TX injector (valid/ready to req/ack)
// and RX receiver with a small circular FIFO toward the PE.
package br_lite_pkg;
    typedef struct packed {
        logic        clear;
        logic [15:0] seq_source;
        logic [7:0]  id;
        logic [31:0] payload;
    } br_data_t;
endpackage

module br_lite_ni
    import br_lite_pkg::*;
#(
    parameter logic [15:0] SEQ_ADDRESS   = 16'h0000,
    parameter int          RX_FIFO_DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,

    input  logic     tx_valid_i,
    output logic     tx_ready_o,
    input  br_data_t tx_flit_i,

    output logic     rx_valid_o,
    input  logic     rx_ready_i,
    output br_data_t rx_flit_o,

    output br_data_t br_flit_o,
    output logic     br_req_o,
    input  logic     br_ack_i,
    input  logic     br_busy_i,

    input  br_data_t br_flit_i,
    input  logic     br_req_i,
    output logic     br_ack_o
);

    localparam int AW = $clog2(RX_FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(RX_FIFO_DEPTH);
    localparam int IDW = $bits(tx_flit_i.id);

    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_REQ  = 1'b1;
    localparam logic [0:0] RX_IDLE = 1'b0;
    localparam logic [0:0] RX_ACK  = 1'b1;

    // ---------------- TX path ----------------
    logic [0:0]     tx_state;
    logic [IDW-1:0] id_cnt;
    br_data_t       tx_flit_q;
    logic           tx_accept;

    assign tx_ready_o = !rst_i && (tx_state == TX_IDLE) && !br_busy_i;
    assign tx_accept  = tx_valid_i && tx_ready_o;
    assign br_req_o   = (tx_state == TX_REQ);
    assign br_flit_o  = tx_flit_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state <= TX_IDLE;
            id_cnt   <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_accept) begin
                        tx_state <= TX_REQ;
                        id_cnt   <= id_cnt + IDW'(1);
                    end
                end
                TX_REQ: begin
                    // A router with a full CAM never acks; we simply keep requesting.
                    if (br_ack_i) tx_state <= TX_IDLE;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // NOTE: datapath registers whose value is irrelevant until a valid/req
    // qualifies them are left unreset; only control state needs a known value.
    always_ff @(posedge clk_i) begin
        if (tx_accept) begin
            tx_flit_q            <= tx_flit_i;
            tx_flit_q.seq_source <= SEQ_ADDRESS;
            tx_flit_q.id         <= id_cnt;
            tx_flit_q.clear      <= 1'b0;
        end
    end

    // ---------------- RX path ----------------
    logic [0:0]    rx_state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    br_data_t      mem [RX_FIFO_DEPTH];
    logic          full;
    logic          rx_take;
    logic          push;
    logic          pop;

    // full comes from the registered count, so a same-cycle pop cannot make room.
    assign full       = (count == DEPTH_C);
    assign rx_take    = (rx_state == RX_IDLE) && br_req_i && (br_flit_i.clear || !full);
    assign push       = rx_take && !br_flit_i.clear;
    assign rx_valid_o = (count != '0);
    assign pop        = rx_valid_o && rx_ready_i;
    assign br_ack_o   = (rx_state == RX_ACK);
    assign rx_flit_o  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state <= RX_IDLE;
        end else begin
            case (rx_state)
                RX_IDLE: if (rx_take) rx_state <= RX_ACK;
                RX_ACK:  rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= br_flit_i;
    end

endmodule

// File: tb/tb_br_lite_ni.sv
// Directed self-checking bench for br_lite_ni: TX send/busy/stall, RX fill,
// pointer wrap, clear discard and mid-handshake reset.
module tb_br_lite_ni;
    import br_lite_pkg::*;

    logic     clk_i = 1'b0;
    logic     rst_i;
    logic     tx_valid_i;
    logic     tx_ready_o;
    br_data_t tx_flit_i;
    logic     rx_valid_o;
    logic     rx_ready_i;
    br_data_t rx_flit_o;
    br_data_t br_flit_o;
    logic     br_req_o;
    logic     br_ack_i;
    logic     br_busy_i;
    br_data_t br_flit_i;
    logic     br_req_i;
    logic     br_ack_o;

    int n_cmp = 0;
    int n_bad = 0;

    br_lite_ni #(.SEQ_ADDRESS(16'h0102), .RX_FIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_flit_i(tx_flit_i),
        .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_flit_o(rx_flit_o),
        .br_flit_o(br_flit_o), .br_req_o(br_req_o), .br_ack_i(br_ack_i),
        .br_busy_i(br_busy_i), .br_flit_i(br_flit_i), .br_req_i(br_req_i),
        .br_ack_o(br_ack_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tx_valid_i = 1'b1;
        tick();
        tick();
        #1;
        n_cmp++;
        if (tx_ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_tx_ready got=%b want=0", tx_ready_o); end
        n_cmp++;
        if (br_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_br_req got=%b want=0", br_req_o); end
        n_cmp++;
        if (br_ack_o !== 1'b0) begin n_bad++; $display("FAIL rst_br_ack got=%b want=0", br_ack_o); end
        n_cmp++;
        if (rx_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_rx_valid got=%b want=0", rx_valid_o); end
        tx_valid_i = 1'b0;
        rst_i = 1'b0;
        tick();
        n_cmp++;
        if (tx_ready_o !== 1'b1) begin n_bad++; $display("FAIL post_rst_tx_ready got=%b want=1", tx_ready_o); end
        n_cmp++;
        if (br_req_o !== 1'b0) begin n_bad++; $display("FAIL post_rst_br_req got=%b want=0", br_req_o); end
    endtask

    task automatic test_single_send();
        br_data_t exp;
        int req_cycles;
        exp = '{clear: 1'b0, seq_source: 16'h0102, id: 8'h00, payload: 32'hDEADBEEF};
        tx_flit_i = '{clear: 1'b1, seq_source: 16'hFFFF, id: 8'hAA, payload: 32'hDEADBEEF};
        tx_valid_i = 1'b1;
        #1;
        n_cmp++;
        if (tx_ready_o !== 1'b1) begin n_bad++; $display("FAIL send_ready got=%b want=1", tx_ready_o); end
        tick();
        tx_valid_i = 1'b0;
        req_cycles = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 1) begin
                n_cmp++;
                if (br_req_o !== 1'b1) begin n_bad++; $display("FAIL send_req_rise got=%b want=1", br_req_o); end
                n_cmp++;
                if (br_flit_o !== exp) begin n_bad++; $display("FAIL send_flit got=%h want=%h", br_flit_o, exp); end
            end
            if (br_req_o === 1'b1) req_cycles++;
            br_ack_i = (k == 5);
            tick();
        end
        br_ack_i = 1'b0;
        n_cmp++;
        if (req_cycles != 5) begin n_bad++; $display("FAIL send_req_len got=%0d want=5", req_cycles); end
    endtask

    task automatic test_busy_and_stall();
        br_data_t exp;
        int bad;
        exp = '{clear: 1'b0, seq_source: 16'h0102, id: 8'h01, payload: 32'h11112222};
        br_busy_i = 1'b1;
        tx_flit_i = '{clear: 1'b0, seq_source: 16'h0000, id: 8'h00, payload: 32'h11112222};
        tx_valid_i = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (tx_ready_o !== 1'b0 || br_req_o !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL busy_gate bad_cycles=%0d want=0", bad); end
        br_busy_i = 1'b0;
        #1;
        n_cmp++;
        if (tx_ready_o !== 1'b1) begin n_bad++; $display("FAIL busy_release_ready got=%b want=1", tx_ready_o); end
        tick();
        n_cmp++;
        if (br_req_o !== 1'b1 || br_flit_o !== exp) begin
            n_bad++; $display("FAIL busy_accept req=%b flit=%h want req=1 flit=%h", br_req_o, br_flit_o, exp);
        end
        // Router stall: PE keeps offering a new flit that must not be taken.
        tx_flit_i.payload = 32'h33334444;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (br_req_o !== 1'b1 || br_flit_o !== exp || tx_ready_o !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL stall_hold bad_cycles=%0d want=0", bad); end
        br_ack_i = 1'b1;
        tx_valid_i = 1'b0;
        tick();
        br_ack_i = 1'b0;
        n_cmp++;
        if (br_req_o !== 1'b0) begin n_bad++; $display("FAIL stall_release got=%b want=0", br_req_o); end
        tick();
        n_cmp++;
        if (br_req_o !== 1'b0) begin n_bad++; $display("FAIL stall_no_reaccept got=%b want=0", br_req_o); end
    endtask

    task automatic test_rx_fill();
        br_data_t f [5];
        int good;
        int bad;
        for (int i = 0; i < 5; i++)
            f[i] = '{clear: 1'b0, seq_source: 16'h0100 + 16'(i), id: 8'h40 + 8'(i), payload: 32'hA0000000 + 32'(i)};
        rx_ready_i = 1'b0;
        good = 0;
        for (int i = 0; i < 4; i++) begin
            br_flit_i = f[i];
            br_req_i = 1'b1;
            tick();
            if (br_ack_o === 1'b1) begin
                br_req_i = 1'b0;
                tick();
                if (br_ack_o === 1'b0) good++;
            end else begin
                br_req_i = 1'b0;
                tick();
            end
        end
        n_cmp++;
        if (good != 4) begin n_bad++; $display("FAIL rx_fill_pulses got=%0d want=4", good); end
        n_cmp++;
        if (rx_valid_o !== 1'b1 || rx_flit_o !== f[0]) begin
            n_bad++; $display("FAIL rx_head valid=%b flit=%h want valid=1 flit=%h", rx_valid_o, rx_flit_o, f[0]);
        end
        br_flit_i = f[4];
        br_req_i = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (br_ack_o !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL rx_full_noack acks=%0d want=0", bad); end
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        n_cmp++;
        if (br_ack_o !== 1'b0) begin n_bad++; $display("FAIL rx_pop_same_cycle_ack got=%b want=0", br_ack_o); end
        tick();
        n_cmp++;
        if (br_ack_o !== 1'b1) begin n_bad++; $display("FAIL rx_fifth_ack got=%b want=1", br_ack_o); end
        br_req_i = 1'b0;
        tick();
        n_cmp++;
        if (br_ack_o !== 1'b0) begin n_bad++; $display("FAIL rx_fifth_pulse got=%b want=0", br_ack_o); end
        bad = 0;
        rx_ready_i = 1'b1;
        for (int j = 1; j < 5; j++) begin
            if (rx_valid_o !== 1'b1 || rx_flit_o !== f[j]) begin
                bad++; $display("FAIL rx_order idx=%0d got=%h want=%h", j, rx_flit_o, f[j]);
            end
            tick();
        end
        rx_ready_i = 1'b0;
        n_cmp++;
        if (bad != 0) n_bad++;
        n_cmp++;
        if (rx_valid_o !== 1'b0) begin n_bad++; $display("FAIL rx_drained got=%b want=0", rx_valid_o); end
    endtask

    task automatic test_clear_discard();
        br_flit_i = '{clear: 1'b1, seq_source: 16'h0200, id: 8'h55, payload: 32'hC1EA0000};
        br_req_i = 1'b1;
        tick();
        n_cmp++;
        if (br_ack_o !== 1'b1) begin n_bad++; $display("FAIL clear_ack got=%b want=1", br_ack_o); end
        br_req_i = 1'b0;
        tick();
        n_cmp++;
        if (br_ack_o !== 1'b0) begin n_bad++; $display("FAIL clear_pulse got=%b want=0", br_ack_o); end
        tick();
        n_cmp++;
        if (rx_valid_o !== 1'b0) begin n_bad++; $display("FAIL clear_no_push got=%b want=0", rx_valid_o); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            br_flit_i = '{clear: 1'b0, seq_source: 16'h0300, id: 8'(i), payload: 32'hB0000000 + 32'(i)};
            br_req_i = 1'b1;
            tick();
            br_req_i = 1'b0;
            tick();
        end
        tx_flit_i = '{clear: 1'b0, seq_source: 16'h0000, id: 8'h00, payload: 32'h55556666};
        tx_valid_i = 1'b1;
        tick();
        tx_valid_i = 1'b0;
        n_cmp++;
        if (br_req_o !== 1'b1 || br_flit_o.id !== 8'h02 || rx_valid_o !== 1'b1) begin
            n_bad++; $display("FAIL premid req=%b id=%h rxv=%b want req=1 id=02 rxv=1", br_req_o, br_flit_o.id, rx_valid_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_cmp++;
        if (br_req_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_req got=%b want=0", br_req_o); end
        n_cmp++;
        if (rx_valid_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_rx_valid got=%b want=0", rx_valid_o); end
        tick();
        tx_valid_i = 1'b1;
        tick();
        tx_valid_i = 1'b0;
        n_cmp++;
        if (br_req_o !== 1'b1 || br_flit_o.id !== 8'h00 || br_flit_o.payload !== 32'h55556666) begin
            n_bad++; $display("FAIL post_rst_send req=%b id=%h pl=%h want req=1 id=00 pl=55556666", br_req_o, br_flit_o.id, br_flit_o.payload);
        end
        br_ack_i = 1'b1;
        tick();
        br_ack_i = 1'b0;
        n_cmp++;
        if (br_req_o !== 1'b0) begin n_bad++; $display("FAIL post_rst_release got=%b want=0", br_req_o); end
    endtask

    initial begin
        rst_i = 1'b1;
        tx_valid_i = 1'b0;
        tx_flit_i = '0;
        rx_ready_i = 1'b0;
        br_ack_i = 1'b0;
        br_busy_i = 1'b0;
        br_flit_i = '0;
        br_req_i = 1'b0;
        test_reset();
        test_single_send();
        test_busy_and_stall();
        test_rx_fill();
        test_clear_discard();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
